// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes and
// immediate formats used by the decode stage and its helpers.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_NOP     = 4'd9,
    CLS_ILLEGAL = 4'd10
  } instr_class_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-decode handshake.
// Valid/ready: an instruction transfers on the rising clk edge where
// if_valid && id_ready; while if_valid && !id_ready the fetch side holds
// if_instr/if_pc stable. id_ready may depend combinationally on if_valid
// and if_instr (hazard check), never the other way around.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  modport master (output if_valid, if_instr, if_pc, input id_ready);
  modport slave  (input if_valid, if_instr, if_pc, output id_ready);
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediates, zero otherwise.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [31:0]     instr_i,
  input  imm_type_t       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  // Select the bit-scatter for the instruction format; instr[31] is the sign.
  always_comb begin
    imm32 = '0;
    case (imm_type_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'h000};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: class decode, register file read requests, RAW
// interlock against EX and EX/MEM writers, ID/EX pipeline register and a
// saturating hazard-stall counter.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = rv_pkg::XLEN,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  id_stage_if.slave            fetch,
  input  logic                 flush,
  output logic                 rf_read_enable1,
  output logic                 rf_read_enable2,
  output logic [ADDR_SIZE-1:0] rf_read_addr1,
  output logic [ADDR_SIZE-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  input  logic                 mem_rd_we,
  input  logic [ADDR_SIZE-1:0] mem_rd,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_data,
  output logic [XLEN-1:0]      ex_rs2_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [ADDR_SIZE-1:0] ex_rd,
  output logic                 ex_rd_we,
  output logic [3:0]           ex_op_class,
  output logic [2:0]           ex_funct3,
  output logic                 ex_alt,
  output logic                 ex_illegal,
  output logic [31:0]          stall_count
);

  logic [31:0]          instr;
  logic [6:0]           opcode;
  logic [ADDR_SIZE-1:0] rs1_addr, rs2_addr, rd_addr;

  assign instr    = fetch.if_instr;
  assign opcode   = instr[6:0];
  assign rs1_addr = instr[15 +: ADDR_SIZE];
  assign rs2_addr = instr[20 +: ADDR_SIZE];
  assign rd_addr  = instr[7 +: ADDR_SIZE];

  instr_class_t    dec_class;
  imm_type_t       imm_type;
  logic            rs1_used, rs2_used, dec_writes, dec_alt;
  logic [XLEN-1:0] dec_imm;

  // Opcode decode; any unknown opcode (including instr[1:0] != 11) is illegal.
  always_comb begin
    dec_class  = CLS_ILLEGAL;
    imm_type   = IMM_NONE;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    dec_writes = 1'b0;
    dec_alt    = 1'b0;
    case (opcode)
      OPC_LUI:    begin dec_class = CLS_LUI;   imm_type = IMM_U; dec_writes = 1'b1; end
      OPC_AUIPC:  begin dec_class = CLS_AUIPC; imm_type = IMM_U; dec_writes = 1'b1; end
      OPC_JAL:    begin dec_class = CLS_JAL;   imm_type = IMM_J; dec_writes = 1'b1; end
      OPC_JALR:   begin
        dec_class = CLS_JALR; imm_type = IMM_I; dec_writes = 1'b1; rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        dec_class = CLS_BRANCH; imm_type = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_LOAD:   begin
        dec_class = CLS_LOAD; imm_type = IMM_I; dec_writes = 1'b1; rs1_used = 1'b1;
      end
      OPC_STORE:  begin
        dec_class = CLS_STORE; imm_type = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_class  = CLS_OP_IMM; imm_type = IMM_I; dec_writes = 1'b1; rs1_used = 1'b1;
        // Only the shift-right pair uses instr[30] to pick SRAI over SRLI.
        dec_alt    = (instr[14:12] == 3'b101) ? instr[30] : 1'b0;
      end
      OPC_OP:     begin
        dec_class  = CLS_OP; dec_writes = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        dec_alt    = instr[30];
      end
      OPC_FENCE:  dec_class = CLS_NOP;
      default:    dec_class = CLS_ILLEGAL;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i    (instr),
    .imm_type_i (imm_type),
    .imm_o      (dec_imm)
  );

  assign rf_read_enable1 = fetch.if_valid & rs1_used;
  assign rf_read_enable2 = fetch.if_valid & rs2_used;
  assign rf_read_addr1   = rs1_addr;
  assign rf_read_addr2   = rs2_addr;

  logic                 ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]      ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]      ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0]      ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0]      ex_imm_q, ex_imm_d;
  logic [ADDR_SIZE-1:0] ex_rd_q, ex_rd_d;
  logic                 ex_rd_we_q, ex_rd_we_d;
  logic [3:0]           ex_class_q, ex_class_d;
  logic [2:0]           ex_funct3_q, ex_funct3_d;
  logic                 ex_alt_q, ex_alt_d;
  logic                 ex_illegal_q, ex_illegal_d;
  logic [31:0]          stall_q, stall_d;
  logic                 hazard;

  // RAW interlock: no forwarding, so wait until the writer reaches write-back
  // (which writes through the register file and is not checked here).
  always_comb begin
    logic ex_w, hz1, hz2;
    ex_w   = ex_valid_q & ex_rd_we_q;
    hz1    = rs1_used & (rs1_addr != '0) &
             ((ex_w & (ex_rd_q == rs1_addr)) | (mem_rd_we & (mem_rd == rs1_addr)));
    hz2    = rs2_used & (rs2_addr != '0) &
             ((ex_w & (ex_rd_q == rs2_addr)) | (mem_rd_we & (mem_rd == rs2_addr)));
    hazard = fetch.if_valid & (hz1 | hz2);
  end

  // A flush swallows whatever fetch is offering, so it is always accepted.
  assign fetch.id_ready = flush | (~hazard & (~ex_valid_q | ex_ready));

  // ID/EX next state: flush > hold on backpressure > bubble on hazard > load.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_we_d   = ex_rd_we_q;
    ex_class_d   = ex_class_q;
    ex_funct3_d  = ex_funct3_q;
    ex_alt_d     = ex_alt_q;
    ex_illegal_d = ex_illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_valid_q && !ex_ready) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
    end else if (fetch.if_valid) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = fetch.if_pc;
      ex_rs1_d     = rf_read_data1;
      ex_rs2_d     = rf_read_data2;
      ex_imm_d     = dec_imm;
      ex_rd_d      = rd_addr;
      ex_rd_we_d   = dec_writes & (rd_addr != '0);
      ex_class_d   = dec_class;
      ex_funct3_d  = instr[14:12];
      ex_alt_d     = dec_alt;
      ex_illegal_d = (dec_class == CLS_ILLEGAL);
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  // Saturating count of cycles lost to the interlock; flush cycles excluded.
  always_comb begin
    stall_d = stall_q;
    if (hazard && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // ID/EX register and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_rd_we_q   <= 1'b0;
      ex_class_q   <= '0;
      ex_funct3_q  <= '0;
      ex_alt_q     <= 1'b0;
      ex_illegal_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_we_q   <= ex_rd_we_d;
      ex_class_q   <= ex_class_d;
      ex_funct3_q  <= ex_funct3_d;
      ex_alt_q     <= ex_alt_d;
      ex_illegal_q <= ex_illegal_d;
      stall_q      <= stall_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rd_we    = ex_rd_we_q;
  assign ex_op_class = ex_class_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_alt      = ex_alt_q;
  assign ex_illegal  = ex_illegal_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: scenario tasks plus a scoreboard that checks every
// ID/EX bundle handed to execute against a reference decode model.
module tb_id_stage;
  import rv_pkg::*;

  localparam int EW = 145;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        rf_read_enable1, rf_read_enable2;
  logic [4:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        mem_rd_we;
  logic [4:0]  mem_rd;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [3:0]  ex_op_class;
  logic [2:0]  ex_funct3;
  logic        ex_alt, ex_illegal;
  logic [31:0] stall_count;

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // clock / reset block
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) fetch ();

  id_stage #(.XLEN(32), .ADDR_SIZE(5)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .flush(flush),
    .rf_read_enable1(rf_read_enable1), .rf_read_enable2(rf_read_enable2),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .mem_rd_we(mem_rd_we), .mem_rd(mem_rd), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_op_class(ex_op_class), .ex_funct3(ex_funct3),
    .ex_alt(ex_alt), .ex_illegal(ex_illegal), .stall_count(stall_count)
  );

  // register file model: each register holds a value derived from its index
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return {3'b000, a, 8'hA5, 3'b000, a, 8'h5A};
  endfunction

  assign rf_read_data1 = rf_val(rf_read_addr1);
  assign rf_read_data2 = rf_val(rf_read_addr2);

  // reference decode: {pc, rs1, rs2, imm, rd, rd_we, class, f3, alt, ill, use1, use2}
  function automatic logic [EW-1:0] model(input logic [31:0] i, input logic [31:0] pc);
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        wr, u1, u2, alt, ill;
    cls = CLS_ILLEGAL; imm = 32'h0; wr = 0; u1 = 0; u2 = 0; alt = 0; ill = 0;
    case (i[6:0])
      7'b0110111: begin cls = CLS_LUI;   imm = {i[31:12], 12'h0}; wr = 1; end
      7'b0010111: begin cls = CLS_AUIPC; imm = {i[31:12], 12'h0}; wr = 1; end
      7'b1101111: begin
        cls = CLS_JAL; wr = 1;
        imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100111: begin cls = CLS_JALR; imm = {{20{i[31]}}, i[31:20]}; wr = 1; u1 = 1; end
      7'b1100011: begin
        cls = CLS_BRANCH; u1 = 1; u2 = 1;
        imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0000011: begin cls = CLS_LOAD; imm = {{20{i[31]}}, i[31:20]}; wr = 1; u1 = 1; end
      7'b0100011: begin
        cls = CLS_STORE; u1 = 1; u2 = 1; imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b0010011: begin
        cls = CLS_OP_IMM; imm = {{20{i[31]}}, i[31:20]}; wr = 1; u1 = 1;
        alt = (i[14:12] == 3'b101) && i[30];
      end
      7'b0110011: begin cls = CLS_OP; wr = 1; u1 = 1; u2 = 1; alt = i[30]; end
      7'b0001111: cls = CLS_NOP;
      default:    ill = 1;
    endcase
    return {pc, rf_val(i[19:15]), rf_val(i[24:20]), imm, i[11:7],
            wr && (i[11:7] != 5'd0), cls, i[14:12], alt, ill, u1, u2};
  endfunction

  // scoreboard: a bundle is consumed by execute on each edge with valid & ready
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected bundle pc=%h appeared, none expected", ex_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (ex_pc !== mon_e[144:113]) begin miscompares++; $display("FAIL sb_pc got %h required %h", ex_pc, mon_e[144:113]); end
        vectors++;
        if (ex_imm !== mon_e[48:17]) begin miscompares++; $display("FAIL sb_imm pc=%h got %h required %h", ex_pc, ex_imm, mon_e[48:17]); end
        vectors++;
        if (ex_op_class !== mon_e[10:7]) begin miscompares++; $display("FAIL sb_class pc=%h got %0d required %0d", ex_pc, ex_op_class, mon_e[10:7]); end
        vectors++;
        if (ex_rd_we !== mon_e[11]) begin miscompares++; $display("FAIL sb_rd_we pc=%h got %b required %b", ex_pc, ex_rd_we, mon_e[11]); end
        vectors++;
        if ({ex_funct3, ex_alt, ex_illegal} !== mon_e[6:2]) begin
          miscompares++; $display("FAIL sb_f3_alt_ill pc=%h got %b required %b", ex_pc, {ex_funct3, ex_alt, ex_illegal}, mon_e[6:2]);
        end
        if (mon_e[11]) begin
          vectors++;
          if (ex_rd !== mon_e[16:12]) begin miscompares++; $display("FAIL sb_rd pc=%h got %0d required %0d", ex_pc, ex_rd, mon_e[16:12]); end
        end
        if (mon_e[1]) begin
          vectors++;
          if (ex_rs1_data !== mon_e[112:81]) begin miscompares++; $display("FAIL sb_rs1 pc=%h got %h required %h", ex_pc, ex_rs1_data, mon_e[112:81]); end
        end
        if (mon_e[0]) begin
          vectors++;
          if (ex_rs2_data !== mon_e[80:49]) begin miscompares++; $display("FAIL sb_rs2 pc=%h got %h required %h", ex_pc, ex_rs2_data, mon_e[80:49]); end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] pc, input bit rand_rdy);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    fetch.if_valid = 1'b1;
    fetch.if_instr = i;
    fetch.if_pc    = pc;
    while (!done) begin
      if (rand_rdy) ex_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (fetch.id_ready) begin
        exp_q.push_back(model(i, pc));
        done = 1;
      end else if (waited >= 20) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout pc=%h id_ready got 0, required 1 within 20 cycles", pc);
        done = 1;
      end
      waited++;
      tick();
    end
    fetch.if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; ex_ready = 1; mem_rd_we = 0; mem_rd = 0;
    fetch.if_valid = 0; fetch.if_instr = 32'h0; fetch.if_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b required 0", ex_valid); end
    vectors++;
    if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rd_we, ex_op_class,
         ex_funct3, ex_alt, ex_illegal} !== '0) begin
      miscompares++; $display("FAIL reset_fields got pc=%h imm=%h class=%0d required all zero", ex_pc, ex_imm, ex_op_class);
    end
    vectors++;
    if (stall_count !== 32'd0) begin miscompares++; $display("FAIL reset_stall got %0d required 0", stall_count); end
    vectors++;
    if (fetch.id_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b required 1", fetch.id_ready); end
    tick();
  endtask

  task automatic test_addi();
    fetch.if_valid = 1; fetch.if_instr = 32'h00500093; fetch.if_pc = 32'h100;
    @(negedge clk);
    vectors++;
    if ({rf_read_enable1, rf_read_enable2} !== 2'b10) begin miscompares++; $display("FAIL addi_rden got %b required 10", {rf_read_enable1, rf_read_enable2}); end
    vectors++;
    if (fetch.id_ready !== 1'b1) begin miscompares++; $display("FAIL addi_ready got %b required 1", fetch.id_ready); end
    exp_q.push_back(model(32'h00500093, 32'h100));
    tick();
    fetch.if_valid = 0;
    @(negedge clk);
    vectors++;
    if ({ex_valid, ex_op_class, ex_imm, ex_rd, ex_rd_we} !== {1'b1, 4'd7, 32'd5, 5'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL addi_bundle got v=%b cls=%0d imm=%h rd=%0d we=%b required v=1 cls=7 imm=5 rd=1 we=1",
               ex_valid, ex_op_class, ex_imm, ex_rd, ex_rd_we);
    end
    tick();
  endtask

  task automatic test_raw_hazard();
    logic [31:0] sc0;
    sc0 = stall_count;
    fetch.if_valid = 1; fetch.if_instr = 32'h0000A103; fetch.if_pc = 32'h200;
    @(negedge clk);
    exp_q.push_back(model(32'h0000A103, 32'h200));
    tick();
    fetch.if_instr = 32'h002101B3; fetch.if_pc = 32'h204;
    @(negedge clk);
    vectors++;
    if (fetch.id_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_ex id_ready got %b required 0", fetch.id_ready); end
    tick();
    mem_rd_we = 1; mem_rd = 5'd2;
    @(negedge clk);
    vectors++;
    if ({fetch.id_ready, ex_valid} !== 2'b00) begin miscompares++; $display("FAIL raw_stall_mem ready,valid got %b required 00", {fetch.id_ready, ex_valid}); end
    tick();
    mem_rd_we = 0; mem_rd = 5'd0;
    @(negedge clk);
    vectors++;
    if ({fetch.id_ready, ex_valid} !== 2'b10) begin miscompares++; $display("FAIL raw_release ready,valid got %b required 10", {fetch.id_ready, ex_valid}); end
    vectors++;
    if (stall_count !== sc0 + 32'd2) begin miscompares++; $display("FAIL raw_stall_count got %0d required %0d", stall_count, sc0 + 32'd2); end
    exp_q.push_back(model(32'h002101B3, 32'h204));
    tick();
    fetch.if_valid = 0;
    @(negedge clk);
    vectors++;
    if ({ex_valid, ex_rs1_data, ex_rs2_data} !== {1'b1, rf_val(5'd2), rf_val(5'd2)}) begin
      miscompares++; $display("FAIL raw_issue got v=%b rs1=%h rs2=%h required v=1 rs=%h", ex_valid, ex_rs1_data, ex_rs2_data, rf_val(5'd2));
    end
    tick();
  endtask

  task automatic test_branch();
    fetch.if_valid = 1; fetch.if_instr = 32'h00000013; fetch.if_pc = 32'h300;
    @(negedge clk);
    exp_q.push_back(model(32'h00000013, 32'h300));
    tick();
    mem_rd_we = 1; mem_rd = 5'd0;
    fetch.if_instr = 32'hFE000EE3; fetch.if_pc = 32'h304;
    @(negedge clk);
    vectors++;
    if ({fetch.id_ready, rf_read_enable1, rf_read_enable2} !== 3'b111) begin
      miscompares++; $display("FAIL beq_no_hazard ready,rden got %b required 111", {fetch.id_ready, rf_read_enable1, rf_read_enable2});
    end
    exp_q.push_back(model(32'hFE000EE3, 32'h304));
    tick();
    fetch.if_valid = 0; mem_rd_we = 0;
    @(negedge clk);
    vectors++;
    if ({ex_imm, ex_op_class, ex_rd_we} !== {32'hFFFFFFFC, 4'd4, 1'b0}) begin
      miscompares++; $display("FAIL beq_bundle got imm=%h cls=%0d we=%b required imm=fffffffc cls=4 we=0", ex_imm, ex_op_class, ex_rd_we);
    end
    tick();
  endtask

  task automatic test_backpressure();
    fetch.if_valid = 1; fetch.if_instr = 32'h00700293; fetch.if_pc = 32'h400;
    @(negedge clk);
    exp_q.push_back(model(32'h00700293, 32'h400));
    tick();
    ex_ready = 0;
    fetch.if_instr = 32'h00900313; fetch.if_pc = 32'h404;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({fetch.id_ready, ex_valid, ex_pc, ex_imm} !== {1'b0, 1'b1, 32'h400, 32'd7}) begin
        miscompares++; $display("FAIL bp_hold cycle %0d got ready=%b v=%b pc=%h imm=%h required 0 1 400 7", c, fetch.id_ready, ex_valid, ex_pc, ex_imm);
      end
      tick();
    end
    ex_ready = 1;
    @(negedge clk);
    vectors++;
    if (fetch.id_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release id_ready got %b required 1", fetch.id_ready); end
    exp_q.push_back(model(32'h00900313, 32'h404));
    tick();
    fetch.if_valid = 0;
    @(negedge clk);
    vectors++;
    if ({ex_pc, ex_imm} !== {32'h404, 32'd9}) begin miscompares++; $display("FAIL bp_next got pc=%h imm=%h required 404 9", ex_pc, ex_imm); end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] sc1;
    fetch.if_valid = 1; fetch.if_instr = 32'h0000A103; fetch.if_pc = 32'h500;
    @(negedge clk);
    exp_q.push_back(model(32'h0000A103, 32'h500));
    tick();
    ex_ready = 0;
    fetch.if_instr = 32'h002101B3; fetch.if_pc = 32'h504;
    @(negedge clk);
    vectors++;
    if (fetch.id_ready !== 1'b0) begin miscompares++; $display("FAIL flush_pre_stall id_ready got %b required 0", fetch.id_ready); end
    sc1 = stall_count;
    tick();
    flush = 1;
    @(negedge clk);
    vectors++;
    if (fetch.id_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b required 1", fetch.id_ready); end
    void'(exp_q.pop_front());
    tick();
    flush = 0; fetch.if_valid = 0; ex_ready = 1;
    @(negedge clk);
    vectors++;
    if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_clears ex_valid got %b required 0", ex_valid); end
    vectors++;
    if (stall_count !== sc1 + 32'd1) begin miscompares++; $display("FAIL flush_no_count got %0d required %0d", stall_count, sc1 + 32'd1); end
    tick();
    // reset in the middle of a stall
    fetch.if_valid = 1; fetch.if_instr = 32'h0000A103; fetch.if_pc = 32'h600;
    @(negedge clk);
    exp_q.push_back(model(32'h0000A103, 32'h600));
    tick();
    ex_ready = 0;
    fetch.if_instr = 32'h002101B3; fetch.if_pc = 32'h604;
    tick();
    rst = 1;
    tick();
    rst = 0; fetch.if_valid = 0; ex_ready = 1;
    void'(exp_q.pop_front());
    @(negedge clk);
    vectors++;
    if ({ex_valid, stall_count} !== {1'b0, 32'd0}) begin miscompares++; $display("FAIL rst_mid_stall got v=%b stall=%0d required 0 0", ex_valid, stall_count); end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] words [3];
    logic [3:0]  cls [3];
    logic        ill [3];
    words = '{32'hFFFFFFFF, 32'h00000000, 32'h0000000F};
    cls   = '{4'd10, 4'd10, 4'd9};
    ill   = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      fetch.if_valid = 1; fetch.if_instr = words[k]; fetch.if_pc = 32'h800 + 32'(4 * k);
      @(negedge clk);
      vectors++;
      if ({rf_read_enable1, rf_read_enable2} !== 2'b00) begin miscompares++; $display("FAIL ill_rden word=%h got %b required 00", words[k], {rf_read_enable1, rf_read_enable2}); end
      exp_q.push_back(model(words[k], 32'h800 + 32'(4 * k)));
      tick();
      fetch.if_valid = 0;
      @(negedge clk);
      vectors++;
      if ({ex_illegal, ex_op_class, ex_rd_we} !== {ill[k], cls[k], 1'b0}) begin
        miscompares++; $display("FAIL ill_bundle word=%h got ill=%b cls=%0d we=%b required ill=%b cls=%0d we=0",
                                words[k], ex_illegal, ex_op_class, ex_rd_we, ill[k], cls[k]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    fetch.if_valid = 1;
    for (int k = 0; k < 8; k++) begin
      w = {20'(k + 1), 5'(k + 1), 7'b0110111};
      fetch.if_instr = w; fetch.if_pc = 32'h900 + 32'(4 * k);
      @(negedge clk);
      vectors++;
      if (fetch.id_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready k=%0d got %b required 1", k, fetch.id_ready); end
      if (k > 0) begin
        vectors++;
        if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid k=%0d got %b required 1", k, ex_valid); end
      end
      exp_q.push_back(model(w, 32'h900 + 32'(4 * k)));
      tick();
    end
    fetch.if_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  tab [11];
    logic [31:0] w;
    tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1011011};
    for (int k = 0; k < 40; k++) begin
      w = $urandom();
      w[6:0] = tab[$urandom_range(0, 10)];
      send(w, 32'h1000 + 32'(4 * k), 1'b1);
    end
    ex_ready = 1;
    repeat (4) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_raw_hazard();
    test_branch();
    test_backpressure();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL queue_drained got %0d left required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the pipelined RV32I core. Accepts one fetched instruction per cycle over a valid/ready handshake and drives the register file read ports and enables. Generates the immediate and interlocks on read-after-write hazards against in-flight writers. Registers the decoded bundle into the ID/EX pipeline register that feeds the execute stage.

## Interface
Parameters:
- XLEN, 32, data and PC width
- ADDR_SIZE, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  fetch offers an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  stage accepts the offered instruction this cycle
- flush  in  1  branch/jump redirect; kill ID and ID/EX contents
- rf_read_enable1, rf_read_enable2  out  1  register file read enables
- rf_read_addr1, rf_read_addr2  out  ADDR_SIZE  register file read addresses (rs1, rs2)
- rf_read_data1, rf_read_data2  in  XLEN  register file data, combinational, same cycle
- mem_rd_we  in  1  instruction in EX/MEM writes a register
- mem_rd  in  ADDR_SIZE  its destination
- ex_ready  in  1  execute stage accepts the ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc  out  XLEN  registered PC
- ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
- ex_imm  out  XLEN  sign-extended immediate
- ex_rd  out  ADDR_SIZE  destination register
- ex_rd_we  out  1  destination written (rd≠0 and class writes)
- ex_op_class  out  4  instr_class_t
- ex_funct3  out  3  funct3
- ex_alt  out  1  instr[30] for OP, and for OP_IMM with funct3=101; else 0
- ex_illegal  out  1  illegal instruction marker
- stall_count  out  32  saturating count of hazard-stall cycles

## Operation
- Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, NOP (FENCE, opcode 0001111), ILLEGAL (any other opcode, or instr[1:0]≠11).
- rs1 used: JALR, BRANCH, LOAD, STORE, OP_IMM, OP. rs2 used: BRANCH, STORE, OP.
- Read enables are asserted only when if_valid is high and the operand is used. Addresses are always driven from instr[19:15] and instr[24:20].
- Immediates: I, S, B, U, J formats; sign bit instr[31]. Immediate is 0 for OP, NOP, ILLEGAL.
- ILLEGAL/NOP: no reads, ex_rd_we=0. ILLEGAL passes down with ex_illegal=1.
- Hazard: if_valid and a used rs≠0 equals either (ex_valid & ex_rd_we & ex_rd) or (mem_rd_we & mem_rd). Full interlock, no forwarding. The write-back stage writes through the register file, so it is not a hazard source.
- id_ready = flush | (!hazard & (!ex_valid | ex_ready)).
- ID/EX update, by priority:
  - rst or flush: ex_valid←0.
  - else ex_valid & !ex_ready: hold all outputs.
  - else hazard: bubble, ex_valid←0.
  - else if_valid: load decoded bundle, ex_valid←1.
  - else ex_valid←0.
- Flush accepts the offered instruction (id_ready=1) and discards it.
- stall_count increments each cycle with hazard & !flush & !rst, and saturates at 0xFFFFFFFF.

## Timing
- Decode-to-ID/EX latency is 1 cycle. Throughput is 1/cycle when there is no hazard or backpressure.
- Dependent instruction immediately behind a register writer: 2 bubble cycles (writer in ID/EX, then in EX/MEM).
- Reset values: ex_valid=0, every ex_* field=0, stall_count=0. id_ready follows its equation (1 after reset, since ex_valid=0). rf_* outputs are combinational.
- Reset or flush mid-stall clears ID/EX the next edge. The stall counter does not count a flush cycle.
- Bubble data fields are don't-care; verification checks fields only when ex_valid=1.

## Structure
- Package rv_pkg holds: opcode localparams, instr_class_t (4-bit enum), imm_type_t (I, S, B, U, J, NONE), XLEN default.
- Sub-module imm_gen (combinational: instr, imm_type_t → XLEN immediate).
- The id_stage top holds the class decode, hazard logic, ID/EX register and stall counter.

## Test plan
- addi x1,x0,5 (0x00500093), ex_ready=1 → next cycle ex_valid=1, class OP_IMM, ex_imm=5, ex_rd=1, ex_rd_we=1, rf_read_enable2=0.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3), mem_rd_we driven to model the pipeline → add held 2 cycles with id_ready=0, 2 bubbles, stall_count=2, then add issues with ex_rs1_data=ex_rs2_data=rf data.
- beq x0,x0,-4 (0xFE000EE3) → ex_imm=0xFFFFFFFC, class BRANCH, ex_rd_we=0, no hazard even with ex_rd=0 writer.
- ex_ready=0 for 3 cycles with if_valid=1 → ex_* stable, id_ready=0; on ex_ready=1 the next instruction loads.
- flush asserted during a hazard stall → id_ready=1, ex_valid=0 the next cycle, stall_count unchanged that cycle.
- 0xFFFFFFFF and 0x00000000 → ex_illegal=1, class ILLEGAL, no read enables, ex_rd_we=0.
